ce_md_seq: RTL and testbench

// - Iterative multiply/divide sequencer. It is the write-side controller for the CE HI/LO register pair.
// - Accepts MULT/MULTU/DIV/DIVU from the E stage and runs a 32-step shift-add or restoring-divide sequence.
// - Presents the result to the HI/LO owner as one-cycle write strobes.
// - Stalls any HI/LO access, or a new MD op, arriving while a sequence is in flight.

---
 rtl/ce_md_pkg.sv | 47 ++++
 rtl/ce_md_step.sv | 70 +++++++
 rtl/ce_md_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_ce_md_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_md_pkg.sv
// ----------------------------------------------------------------------------
// ce_md_pkg
// Shared definitions for the CE multiply/divide sequencer:
//   - MD_DW / MD_CNTW : default operand width and iteration counter width
//   - md_op_e         : MD_OP_E encoding (MULT, MULTU, DIV, DIVU)
//   - md_state_e      : sequencer state encoding (IDLE, RUN, FIN)
//   - helper functions that classify an opcode
// ----------------------------------------------------------------------------
package ce_md_pkg;

  localparam int MD_DW   = 32;
  localparam int MD_CNTW = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } md_state_e;

  // True for the two divide opcodes.
  function automatic logic md_op_is_div(input md_op_e op);
    logic res;
    case (op)
      OP_DIV, OP_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

  // True for the two signed opcodes.
  function automatic logic md_op_is_signed(input md_op_e op);
    logic res;
    case (op)
      OP_MULT, OP_DIV: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ce_md_step.sv
// ----------------------------------------------------------------------------
// ce_md_step
// One combinational iteration of the multiply/divide sequence on unsigned
// magnitudes.
//   Multiply: {hi,lo} = {accumulator, multiplier}; conditionally add the
//             multiplicand to the accumulator, then shift the 2*DW+1 result
//             right by one.
//   Divide:   {hi,lo} = {partial remainder, dividend/quotient}; shift left by
//             one, trial-subtract the divisor, keep the difference and shift a
//             1 into the quotient if it does not underflow (restoring).
// Ports:
//   is_div_i  1   selects divide step (else multiply step)
//   hi_i      DW  accumulator / partial remainder
//   lo_i      DW  multiplier / dividend-quotient shift register
//   opd_i     DW  multiplicand / divisor magnitude
//   hi_o      DW  next accumulator / remainder
//   lo_o      DW  next multiplier / quotient
// ----------------------------------------------------------------------------
module ce_md_step
  import ce_md_pkg::*;
#(
  parameter int DW = MD_DW
) (
  input  logic          is_div_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic [DW-1:0] opd_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW:0]   addend_s;
  logic [DW:0]   sum_s;
  logic [DW:0]   shl_s;
  logic [DW-1:0] sub_s;
  logic          ge_s;

  // Single shift-add / restoring-subtract iteration.
  always_comb begin
    addend_s = '0;
    if (lo_i[0]) begin
      addend_s = {1'b0, opd_i};
    end else begin
      addend_s = '0;
    end
    sum_s = {1'b0, hi_i} + addend_s;

    // The remainder is always below the divisor, so the difference of an
    // accepted trial subtract fits in DW bits and the low bits are exact.
    shl_s = {hi_i, lo_i[DW-1]};
    ge_s  = (shl_s >= {1'b0, opd_i});
    sub_s = shl_s[DW-1:0] - opd_i;

    hi_o = '0;
    lo_o = '0;
    if (is_div_i) begin
      if (ge_s) begin
        hi_o = sub_s;
        lo_o = {lo_i[DW-2:0], 1'b1};
      end else begin
        hi_o = shl_s[DW-1:0];
        lo_o = {lo_i[DW-2:0], 1'b0};
      end
    end else begin
      hi_o = sum_s[DW:1];
      lo_o = {sum_s[0], lo_i[DW-1:1]};
    end
  end

endmodule

// File: rtl/ce_md_seq.sv
// ----------------------------------------------------------------------------
// ce_md_seq
// Iterative multiply/divide sequencer; write-side controller of the CE HI/LO
// register pair. An MD op accepted in cycle t runs 32 steps in RUN (t+1..t+32),
// applies the sign fixup and pulses MD_HI_WE/MD_LO_WE in FIN (t+33), then
// returns to IDLE. HI/LO accesses or new MD ops arriving while busy are halted.
// Ports:
//   CLK, RESET_D1_R_N       clock, asynchronous active-low reset
//   CFG_CEENBL              CE enable (gates starts and halts only)
//   CEI_CEHOLD              pipeline hold (blocks starts, never pauses RUN)
//   CEI_XCPN_M              exception in M (kills the op in its first RUN cycle)
//   MD_START_E, MD_OP_E     MD op valid and opcode in E
//   CEI_AOP_E_R, CEI_BOP_E_R rs / rt operands
//   HILO_ACC_E              MFHI/MFLO/MTHI/MTLO in E
//   MD_HI_WE, MD_LO_WE      one-cycle write strobes
//   MD_HI_D, MD_LO_D        write data
//   MD_BUSY                 sequencer not IDLE
//   MD_HALT_E_R             registered halt to the core
// ----------------------------------------------------------------------------
module ce_md_seq
  import ce_md_pkg::*;
#(
  parameter int DW   = MD_DW,
  parameter int CNTW = MD_CNTW
) (
  input  logic          CLK,
  input  logic          RESET_D1_R_N,
  input  logic          CFG_CEENBL,
  input  logic          CEI_CEHOLD,
  input  logic          CEI_XCPN_M,
  input  logic          MD_START_E,
  input  logic [1:0]    MD_OP_E,
  input  logic [DW-1:0] CEI_AOP_E_R,
  input  logic [DW-1:0] CEI_BOP_E_R,
  input  logic          HILO_ACC_E,
  output logic          MD_HI_WE,
  output logic          MD_LO_WE,
  output logic [DW-1:0] MD_HI_D,
  output logic [DW-1:0] MD_LO_D,
  output logic          MD_BUSY,
  output logic          MD_HALT_E_R
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Sequencer state
  md_state_e       state_q;
  logic [CNTW-1:0] cnt_q;
  logic [DW-1:0]   hi_q;
  logic [DW-1:0]   lo_q;
  logic [DW-1:0]   opd_q;
  logic [DW-1:0]   araw_q;
  logic            is_div_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic            dz_q;

  // Registered outputs
  logic            we_q;
  logic            busy_q;
  logic            halt_q;
  logic [DW-1:0]   hi_out_q;
  logic [DW-1:0]   lo_out_q;

  // Combinational helpers
  md_op_e          op_s;
  logic            signed_s;
  logic            div_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [DW-1:0]   a_mag_s;
  logic [DW-1:0]   b_mag_s;
  logic            accept_s;
  logic            halt_d;
  logic [DW-1:0]   step_hi_s;
  logic [DW-1:0]   step_lo_s;
  logic [2*DW-1:0] prod_s;
  logic [2*DW-1:0] prod_fx_s;
  logic [DW-1:0]   hi_res_d;
  logic [DW-1:0]   lo_res_d;

  // Decode the E-stage op and reduce signed operands to magnitude + sign.
  always_comb begin
    op_s     = md_op_e'(MD_OP_E);
    signed_s = md_op_is_signed(op_s);
    div_s    = md_op_is_div(op_s);
    a_neg_s  = signed_s & CEI_AOP_E_R[DW-1];
    b_neg_s  = signed_s & CEI_BOP_E_R[DW-1];
    if (a_neg_s) begin
      a_mag_s = -CEI_AOP_E_R;
    end else begin
      a_mag_s = CEI_AOP_E_R;
    end
    if (b_neg_s) begin
      b_mag_s = -CEI_BOP_E_R;
    end else begin
      b_mag_s = CEI_BOP_E_R;
    end
  end

  assign accept_s = MD_START_E & CFG_CEENBL & ~CEI_CEHOLD & ~halt_q &
                    ~CEI_XCPN_M & (state_q == ST_IDLE);

  // Any HI/LO access or new MD op seen while a sequence is in flight stalls E.
  assign halt_d = (HILO_ACC_E | MD_START_E) & CFG_CEENBL & ~CEI_XCPN_M &
                  (state_q != ST_IDLE);

  ce_md_step #(
    .DW (DW)
  ) u_step (
    .is_div_i (is_div_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opd_i    (opd_q),
    .hi_o     (step_hi_s),
    .lo_o     (step_lo_s)
  );

  // Sign fixup on the output of the final step, plus the divide-by-zero override.
  always_comb begin
    prod_s = {step_hi_s, step_lo_s};
    if (neg_res_q) begin
      prod_fx_s = -prod_s;
    end else begin
      prod_fx_s = prod_s;
    end

    hi_res_d = '0;
    lo_res_d = '0;
    if (dz_q) begin
      // Divide by zero returns the raw dividend, not its magnitude.
      hi_res_d = araw_q;
      lo_res_d = '1;
    end else if (is_div_q) begin
      if (neg_res_q) begin
        lo_res_d = -step_lo_s;
      end else begin
        lo_res_d = step_lo_s;
      end
      if (neg_rem_q) begin
        hi_res_d = -step_hi_s;
      end else begin
        hi_res_d = step_hi_s;
      end
    end else begin
      hi_res_d = prod_fx_s[2*DW-1:DW];
      lo_res_d = prod_fx_s[DW-1:0];
    end
  end

  // Sequencer FSM, datapath registers and registered outputs.
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      araw_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      halt_q    <= 1'b0;
      hi_out_q  <= '0;
      lo_out_q  <= '0;
    end else begin
      halt_q <= halt_d;
      we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= CNT_MAX;
            hi_q      <= '0;
            is_div_q  <= div_s;
            neg_res_q <= a_neg_s ^ b_neg_s;
            neg_rem_q <= div_s & a_neg_s;
            dz_q      <= div_s & (CEI_BOP_E_R == '0);
            araw_q    <= CEI_AOP_E_R;
            if (div_s) begin
              lo_q  <= a_mag_s;
              opd_q <= b_mag_s;
            end else begin
              lo_q  <= b_mag_s;
              opd_q <= a_mag_s;
            end
          end
        end
        ST_RUN: begin
          // The op is in M only during its first RUN cycle; only then can it be killed.
          if (CEI_XCPN_M && (cnt_q == CNT_MAX)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= step_hi_s;
            lo_q  <= step_lo_s;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
              state_q  <= ST_FIN;
              we_q     <= 1'b1;
              hi_out_q <= hi_res_d;
              lo_out_q <= lo_res_d;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MD_HI_WE    = we_q;
  assign MD_LO_WE    = we_q;
  assign MD_HI_D     = hi_out_q;
  assign MD_LO_D     = lo_out_q;
  assign MD_BUSY     = busy_q;
  assign MD_HALT_E_R = halt_q;

endmodule

// File: tb/tb_ce_md_seq.sv
// ----------------------------------------------------------------------------
// tb_ce_md_seq
// Directed self-checking bench for ce_md_seq. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_ce_md_seq;

  logic        CLK = 1'b0;
  logic        RESET_D1_R_N;
  logic        CFG_CEENBL;
  logic        CEI_CEHOLD;
  logic        CEI_XCPN_M;
  logic        MD_START_E;
  logic [1:0]  MD_OP_E;
  logic [31:0] CEI_AOP_E_R;
  logic [31:0] CEI_BOP_E_R;
  logic        HILO_ACC_E;
  logic        MD_HI_WE;
  logic        MD_LO_WE;
  logic [31:0] MD_HI_D;
  logic [31:0] MD_LO_D;
  logic        MD_BUSY;
  logic        MD_HALT_E_R;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  ce_md_seq dut (
    .CLK          (CLK),
    .RESET_D1_R_N (RESET_D1_R_N),
    .CFG_CEENBL   (CFG_CEENBL),
    .CEI_CEHOLD   (CEI_CEHOLD),
    .CEI_XCPN_M   (CEI_XCPN_M),
    .MD_START_E   (MD_START_E),
    .MD_OP_E      (MD_OP_E),
    .CEI_AOP_E_R  (CEI_AOP_E_R),
    .CEI_BOP_E_R  (CEI_BOP_E_R),
    .HILO_ACC_E   (HILO_ACC_E),
    .MD_HI_WE     (MD_HI_WE),
    .MD_LO_WE     (MD_LO_WE),
    .MD_HI_D      (MD_HI_D),
    .MD_LO_D      (MD_LO_D),
    .MD_BUSY      (MD_BUSY),
    .MD_HALT_E_R  (MD_HALT_E_R)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starts one op in the current cycle (t) and waits up to 40 cycles for the
  // write strobe. xc/ceoff/hold: cycle index (relative to t) at which XCPN_M
  // pulses / CEENBL drops / CEHOLD rises, 0 = never. lat = strobe cycle or -1.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int xc, input int ceoff, input int hold,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat,
                       output logic both, output logic busy_ok);
    MD_OP_E = op; CEI_AOP_E_R = a; CEI_BOP_E_R = b; MD_START_E = 1'b1;
    hi = 32'h0; lo = 32'h0; lat = -1; both = 1'b0; busy_ok = 1'b1;
    tick();
    MD_START_E = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      CEI_XCPN_M = (i == xc);
      CFG_CEENBL = !(ceoff > 0 && i >= ceoff);
      CEI_CEHOLD = (hold > 0 && i >= hold);
      if (!MD_BUSY) busy_ok = 1'b0;
      if (MD_HI_WE || MD_LO_WE) begin
        hi = MD_HI_D; lo = MD_LO_D; both = MD_HI_WE && MD_LO_WE; lat = i;
        break;
      end
      tick();
    end
    CEI_XCPN_M = 1'b0; CFG_CEENBL = 1'b1; CEI_CEHOLD = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET_D1_R_N = 1'b0; CFG_CEENBL = 1'b1; CEI_CEHOLD = 1'b0; CEI_XCPN_M = 1'b0;
    MD_START_E = 1'b0; MD_OP_E = 2'b00; CEI_AOP_E_R = 32'h0; CEI_BOP_E_R = 32'h0;
    HILO_ACC_E = 1'b0;
    #3;
    checks++;
    if ({MD_BUSY, MD_HI_WE, MD_LO_WE, MD_HALT_E_R, MD_HI_D, MD_LO_D} !== 68'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b we=%b%b halt=%b hi=%h lo=%h, expected all 0",
               MD_BUSY, MD_HI_WE, MD_LO_WE, MD_HALT_E_R, MD_HI_D, MD_LO_D);
    end
    MD_START_E = 1'b1;  // a start under reset must not take effect
    tick(); tick();
    checks++;
    if (MD_BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_hold_busy: got %b expected 0", MD_BUSY);
    end
    MD_START_E = 1'b0;
    RESET_D1_R_N = 1'b1;
    tick();
  endtask

  task automatic test_multu_timing();
    logic [31:0] hi, lo; int lat; logic both, bok;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, hi, lo, lat, both, bok);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    checks++;
    if (both !== 1'b1) begin errors++; $display("FAIL multu_we_pair: got %b expected 1", both); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy_window: got %b expected 1", bok); end
    checks++;
    if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected FFFFFFFE", hi); end
    checks++;
    if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    checks++;
    if ({MD_BUSY, MD_HI_WE, MD_LO_WE} !== 3'b000) begin
      errors++; $display("FAIL multu_after_fin: got busy/we=%b%b%b expected 000", MD_BUSY, MD_HI_WE, MD_LO_WE);
    end
  endtask

  task automatic test_arith();
    vec_t v [7];
    logic [31:0] hi, lo; int lat; logic both, bok;
    v[0] = {2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    v[1] = {2'b00, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
    v[2] = {2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    v[3] = {2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    v[4] = {2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[5] = {2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    v[6] = {2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    for (int k = 0; k < 7; k++) begin
      do_op(v[k].op, v[k].a, v[k].b, 0, 0, 0, hi, lo, lat, both, bok);
      checks++;
      if ({hi, lo} !== {v[k].hi, v[k].lo} || lat !== 33) begin
        errors++;
        $display("FAIL arith[%0d]: got hi=%h lo=%h lat=%0d expected hi=%h lo=%h lat=33",
                 k, hi, lo, lat, v[k].hi, v[k].lo);
      end
    end
  endtask

  task automatic test_div_edge();
    vec_t v [4];
    logic [31:0] hi, lo; int lat; logic both, bok;
    v[0] = {2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    v[1] = {2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v[2] = {2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    v[3] = {2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int k = 0; k < 4; k++) begin
      do_op(v[k].op, v[k].a, v[k].b, 0, 0, 0, hi, lo, lat, both, bok);
      checks++;
      if ({hi, lo} !== {v[k].hi, v[k].lo}) begin
        errors++;
        $display("FAIL div_edge[%0d]: got hi=%h lo=%h expected hi=%h lo=%h",
                 k, hi, lo, v[k].hi, v[k].lo);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] hi, lo; int lat; logic both, bok;
    logic we_seen;
    MD_OP_E = 2'b01; CEI_AOP_E_R = 32'd5; CEI_BOP_E_R = 32'd5; MD_START_E = 1'b1;
    tick();                       // t+1: op in M
    MD_START_E = 1'b0; CEI_XCPN_M = 1'b1;
    we_seen = MD_HI_WE | MD_LO_WE;
    tick();                       // t+2
    CEI_XCPN_M = 1'b0;
    we_seen = we_seen | MD_HI_WE | MD_LO_WE;
    checks++;
    if (MD_BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", MD_BUSY); end
    checks++;
    if (we_seen !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", we_seen); end
    // New start in t+2 must be accepted immediately.
    do_op(2'b01, 32'd3, 32'd5, 0, 0, 0, hi, lo, lat, both, bok);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_000F || lat !== 33) begin
      errors++; $display("FAIL abort_restart: got hi=%h lo=%h lat=%0d expected 0/F lat=33", hi, lo, lat);
    end
    // Exception one cycle later than M is ignored.
    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 2, 0, 0, hi, lo, lat, both, bok);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 33) begin
      errors++; $display("FAIL late_xcpn: got hi=%h lo=%h lat=%0d expected FFFFFFFF/FFFFFFFE lat=33", hi, lo, lat);
    end
  endtask

  task automatic test_gating();
    logic [31:0] hi, lo; int lat; logic both, bok;
    MD_OP_E = 2'b01; CEI_AOP_E_R = 32'd2; CEI_BOP_E_R = 32'd2; MD_START_E = 1'b1;
    CFG_CEENBL = 1'b0;
    tick();
    checks++;
    if (MD_BUSY !== 1'b0) begin errors++; $display("FAIL start_ce_off: got busy %b expected 0", MD_BUSY); end
    CFG_CEENBL = 1'b1; CEI_CEHOLD = 1'b1;
    tick();
    checks++;
    if (MD_BUSY !== 1'b0) begin errors++; $display("FAIL start_held: got busy %b expected 0", MD_BUSY); end
    CEI_CEHOLD = 1'b0; CEI_XCPN_M = 1'b1;
    tick();
    checks++;
    if (MD_BUSY !== 1'b0) begin errors++; $display("FAIL start_xcpn: got busy %b expected 0", MD_BUSY); end
    CEI_XCPN_M = 1'b0; MD_START_E = 1'b0;
    tick();
    do_op(2'b11, 32'd1000, 32'd33, 0, 5, 0, hi, lo, lat, both, bok);
    checks++;
    if ({hi, lo} !== {32'd10, 32'd30} || lat !== 33) begin
      errors++; $display("FAIL ce_drop_midop: got hi=%h lo=%h lat=%0d expected 0000000A/0000001E lat=33", hi, lo, lat);
    end
    do_op(2'b01, 32'd6, 32'd7, 0, 0, 1, hi, lo, lat, both, bok);
    checks++;
    if ({hi, lo} !== {32'd0, 32'd42} || lat !== 33) begin
      errors++; $display("FAIL hold_midop: got hi=%h lo=%h lat=%0d expected 0/0000002A lat=33", hi, lo, lat);
    end
  endtask

  task automatic test_halt_access();
    int bad; logic we33;
    MD_OP_E = 2'b01; CEI_AOP_E_R = 32'd2; CEI_BOP_E_R = 32'd2; MD_START_E = 1'b1;
    tick();                       // t+1
    MD_START_E = 1'b0;
    tick(); tick(); tick(); tick(); // t+5
    checks++;
    if (MD_HALT_E_R !== 1'b0) begin errors++; $display("FAIL halt_before: got %b expected 0", MD_HALT_E_R); end
    HILO_ACC_E = 1'b1;
    tick();                       // t+6
    bad = 0; we33 = 1'b0;
    for (int k = 6; k <= 34; k++) begin
      if (MD_HALT_E_R !== 1'b1) bad++;
      if (k == 33) we33 = MD_HI_WE & MD_LO_WE;
      tick();
    end                           // now t+35
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL halt_window: got %0d cycles low expected 0", bad); end
    checks++;
    if (we33 !== 1'b1) begin errors++; $display("FAIL halt_we_t33: got %b expected 1", we33); end
    checks++;
    if (MD_HALT_E_R !== 1'b0) begin errors++; $display("FAIL halt_release: got %b expected 0", MD_HALT_E_R); end
    HILO_ACC_E = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int we_cnt; logic got;
    MD_OP_E = 2'b01; CEI_AOP_E_R = 32'd4; CEI_BOP_E_R = 32'd4; MD_START_E = 1'b1;
    tick();                       // t+1, start kept high
    we_cnt = 0;
    for (int k = 1; k <= 35; k++) begin
      if (MD_HI_WE) we_cnt++;
      if (k == 34) begin
        checks++;
        if ({MD_BUSY, MD_HALT_E_R} !== 2'b01) begin
          errors++; $display("FAIL b2b_t34: got busy/halt=%b%b expected 01", MD_BUSY, MD_HALT_E_R);
        end
      end
      if (k == 35) begin
        checks++;
        if ({MD_BUSY, MD_HALT_E_R} !== 2'b00) begin
          errors++; $display("FAIL b2b_t35: got busy/halt=%b%b expected 00", MD_BUSY, MD_HALT_E_R);
        end
      end
      tick();
    end                           // t+36
    MD_START_E = 1'b0;
    checks++;
    if (we_cnt !== 1) begin errors++; $display("FAIL b2b_we_count: got %0d expected 1", we_cnt); end
    checks++;
    if (MD_BUSY !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy %b expected 1", MD_BUSY); end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (MD_LO_WE) begin
        got = 1'b1;
        checks++;
        if ({MD_HI_D, MD_LO_D} !== 64'h0000_0000_0000_0010) begin
          errors++; $display("FAIL b2b_second_result: got hi=%h lo=%h expected 0/10", MD_HI_D, MD_LO_D);
        end
      end
      tick();
    end
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL b2b_second_timeout: got no strobe expected one"); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo; int lat; logic both, bok;
    logic we_seen;
    MD_OP_E = 2'b01; CEI_AOP_E_R = 32'd9; CEI_BOP_E_R = 32'd9; MD_START_E = 1'b1;
    tick();                       // t+1
    MD_START_E = 1'b0;
    for (int k = 0; k < 9; k++) tick(); // t+10
    #2 RESET_D1_R_N = 1'b0;
    #1;
    checks++;
    if ({MD_BUSY, MD_HI_WE, MD_LO_WE, MD_HALT_E_R, MD_HI_D, MD_LO_D} !== 68'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b we=%b%b halt=%b hi=%h lo=%h, expected all 0",
               MD_BUSY, MD_HI_WE, MD_LO_WE, MD_HALT_E_R, MD_HI_D, MD_LO_D);
    end
    tick();
    RESET_D1_R_N = 1'b1;
    we_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      we_seen = we_seen | MD_HI_WE | MD_LO_WE | MD_BUSY;
      tick();
    end
    checks++;
    if (we_seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_we: got %b expected 0", we_seen); end
    do_op(2'b01, 32'd3, 32'd5, 0, 0, 0, hi, lo, lat, both, bok);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_000F || lat !== 33) begin
      errors++; $display("FAIL reset_mid_fresh: got hi=%h lo=%h lat=%0d expected 0/F lat=33", hi, lo, lat);
    end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_arith();
    test_div_edge();
    test_abort();
    test_gating();
    test_halt_access();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
